// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths common to the bridge and the 16x8 register slave,
// plus the requester state encoding.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 4;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter; expired flags that the last permitted wait cycle
// has been reached.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Holds at CNT_MAX rather than wrapping, so a stalled bus keeps expired asserted.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_MAX);

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready command into a SETUP/ACCESS transfer and returns
// read data or a timeout error through a single-entry response register.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    apb_state_t state_q, state_d;

    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;

    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic accept;
    logic xfer_done;
    logic xfer_tmo;
    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // A pending response blocks new commands, including the cycle it drains in.
    assign cmd_ready = (state_q == StIdle) && !rsp_valid_q;
    assign accept    = cmd_valid && cmd_ready;
    // pready wins over a simultaneous timeout.
    assign xfer_done = (state_q == StAccess) && pready;
    assign xfer_tmo  = (state_q == StAccess) && !pready && tmr_expired;

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (xfer_done || xfer_tmo) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output logic: bus strobes are computed from the next state and registered.
    always_comb begin
        psel_d     = (state_d != StIdle);
        penable_d  = (state_d == StAccess);
        tmr_clear  = (state_q == StSetup);
        tmr_enable = (state_q == StAccess) && !pready;
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (xfer_done) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = pwrite_q ? '0 : prdata;
        end else if (xfer_tmo) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (accept) begin
                paddr_q  <= cmd_addr;
                pwrite_q <= cmd_write;
                pwdata_q <= cmd_wdata;
            end
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB requester that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers for the 16×8 APB register slave, and returns read data or an error on a valid/ready response channel. It sits directly upstream of the slave and owns psel/penable sequencing, wait-state handling and a bus timeout. It handles one outstanding transfer at a time and uses a single-entry response register.

## Interface
Parameters:
- ADDR_W, 4, APB address width (16 locations)
- DATA_W, 8, APB data width
- TIMEOUT, 16, max ACCESS cycles without pready before abort (≥2)

Ports:
- pclk  in  1  clock, all state updates on rising edge
- presetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at a rising edge
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
- rsp_rdata  out  DATA_W  read data (0 for writes and for errors)
- rsp_err  out  1  1=transfer timed out
- paddr  out  ADDR_W  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready (may be combinational in the slave)

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready = !rsp_valid. On accept, register addr/write/wdata onto paddr/pwrite/pwdata and go to SETUP.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS. Clear the wait counter.
- ACCESS: psel=1, penable=1. If pready=1:
  - capture rsp_rdata = prdata for a read, or 0 for a write
  - set rsp_err=0 and rsp_valid=1
  - go to IDLE
- ACCESS without pready: increment the wait counter. When the counter reaches TIMEOUT-1 and pready is still 0:
  - set rsp_err=1, rsp_rdata=0, rsp_valid=1
  - go to IDLE
- pready sampled in the same cycle as the timeout takes priority: the transfer completes normally.
- IDLE/SETUP: psel/penable values are as stated for each state. paddr/pwrite/pwdata are registered and hold their last value in IDLE. They change only on command accept and never during SETUP/ACCESS.
- rsp_valid clears on a rsp_ready handshake. rsp_rdata/rsp_err hold their values while rsp_valid=1 && !rsp_ready.
- cmd_ready is combinational from state and rsp_valid. It is 0 in SETUP/ACCESS and while a response is pending, including the cycle in which that response drains.
- pready is ignored outside ACCESS.
- Reset (async, any state including mid-ACCESS):
  - state=IDLE
  - psel=0, penable=0, paddr=0, pwrite=0, pwdata=0
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
  - wait counter cleared
  - the in-flight transfer is dropped with no response
  - cmd_ready=1 after reset deasserts.
- Counter width is $clog2(TIMEOUT). It never wraps: saturate-compare at TIMEOUT-1.

## Timing
- Command accepted at edge E0:
  - SETUP in cycle E0→E1
  - ACCESS from E1
- Zero-wait slave: pready=1 in the first ACCESS cycle, and rsp_valid=1 after E2 (3-edge latency from accept).
- k wait states: rsp_valid after E2+k.
- Timeout: psel drops and rsp_valid/rsp_err rise after edge E1+TIMEOUT.
- Throughput with rsp_ready tied 1: one transfer per 4 cycles (IDLE, SETUP, ACCESS, response-drain IDLE).
- All outputs except cmd_ready are registered.

## Structure
- Shared package apb_pkg holds:
  - apb_state_t enum (IDLE, SETUP, ACCESS)
  - APB_ADDR_W=4 and APB_DATA_W=8 constants, shared with the slave
- One sub-module, apb_wait_timer: clear/enable inputs, expired output, parameter TIMEOUT. It holds the saturating wait counter.
- Top level holds the FSM, the command capture registers and the response register.

## Test plan
- Reset, then write 0x5A to addr 3 into the slave:
  - psel rises 1 cycle after accept; penable 1 cycle later
  - rsp_valid 3 edges after accept with rsp_err=0, rsp_rdata=0x00
- Read addr 3 after the write → rsp_rdata=0x5A, rsp_err=0. Repeat for addr 15 with 0xFF and addr 0 with 0x01 (address boundaries).
- Stub slave inserting 2 wait states:
  - psel=penable=1 held for 3 cycles
  - paddr/pwdata stable throughout
  - rsp_valid at accept+5.
- pready tied 0, TIMEOUT=16:
  - psel drops after exactly 16 ACCESS cycles
  - rsp_err=1, rsp_rdata=0x00
  - next command accepted after the drain
- rsp_ready held 0 for 10 cycles with cmd_valid=1:
  - cmd_ready stays 0 and the response holds
  - on drain the next command is accepted one cycle later
- presetn pulsed low mid-ACCESS:
  - psel/penable/rsp_valid go 0 immediately (asynchronously)
  - no response is emitted
  - the next write/read pair completes correctly
